// File: rtl/conv55_6_pim_feeder.sv
// conv55_6_pim_feeder: builds 5x5 windows from a 6-bit raster pixel stream and feeds one conv55_6 PIM macro.
// Latency: result valid PIM_LAT+1 cycles after the pim_en pulse; pim_en follows the window-completing accept by one cycle.
// Backpressure: one window in flight; pix_ready is low from ISSUE until the result handshake completes.
module conv55_6_pim_feeder #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int DATA_W   = 6,
  parameter int RES_W    = 18,
  parameter int ADDR_W   = 5,
  parameter int PIM_ADDR = 0,
  parameter int PIM_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_W-1:0]     pix_data,
  output logic [25*DATA_W-1:0]  win_data,
  output logic [ADDR_W-1:0]     pim_addr,
  output logic                  pim_en,
  input  logic [RES_W-1:0]      pim_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [RES_W-1:0]      res_data,
  output logic                  res_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW = $clog2(PIM_LAT + 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [LW-1:0]     lat_cnt;
  logic              last_pend;

  // lb[0] holds the oldest of the four buffered lines, lb[3] the newest.
  logic [DATA_W-1:0] lb [4][IMG_W];
  // win[r][c]: r=0 oldest line, c=0 leftmost column.
  logic [DATA_W-1:0] win [5][5];
  logic [DATA_W-1:0] new_col [5];

  logic accept;
  logic col_end;
  logic row_end;
  logic win_done;
  logic lat_done;

  assign accept   = pix_valid && pix_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign win_done = accept && (row >= RW'(4)) && (col >= CW'(4));
  assign lat_done = (lat_cnt == LW'(PIM_LAT - 1));
  assign pim_addr = ADDR_W'(PIM_ADDR);

  // Word k of the PIM bus is window row k/5, column k%5.
  genvar k;
  generate
    for (k = 0; k < 25; k++) begin : g_flat
      assign win_data[DATA_W*k +: DATA_W] = win[k/5][k%5];
    end
  endgenerate

  // Column entering the window: four buffered lines at this col plus the new pixel.
  always_comb begin
    for (int i = 0; i < 5; i++) new_col[i] = '0;
    for (int i = 0; i < 4; i++) new_col[i] = lb[i][col];
    new_col[4] = pix_data;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACCEPT;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_ACCEPT: if (win_done)  state_nx = S_ISSUE;
      S_ISSUE:                 state_nx = S_WAIT;
      S_WAIT:   if (lat_done)  state_nx = S_HOLD;
      S_HOLD:   if (res_ready) state_nx = S_ACCEPT;
      default:                 state_nx = S_ACCEPT;
    endcase
  end

  // Registered handshake/strobe outputs decoded from the next state, plus result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_ready <= 1'b0;
      pim_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      pix_ready <= (state_nx == S_ACCEPT);
      pim_en    <= (state_nx == S_ISSUE);
      if (state == S_ISSUE) begin
        lat_cnt <= '0;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt + LW'(1);
        if (lat_done) begin
          res_data  <= pim_result;
          res_valid <= 1'b1;
          res_last  <= last_pend;
        end
      end else if (state == S_HOLD && res_ready) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end
    end
  end

  // Raster position of the next pixel, and whether the issued window closes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      last_pend <= 1'b0;
    end else if (accept) begin
      if (win_done) last_pend <= row_end && col_end;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // 5x5 window shift register: shifts left by one column per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win[r][c] <= win[r][c+1];
        win[r][4] <= new_col[r];
      end
    end
  end

  // Line buffers: each accept ages the column up one line; storage is never cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][col] <= lb[1][col];
      lb[1][col] <= lb[2][col];
      lb[2][col] <= lb[3][col];
      lb[3][col] <= pix_data;
    end
  end

endmodule

// File: tb/tb_conv55_6_pim_feeder.sv
// Bench for conv55_6_pim_feeder: 6x6 frames, PIM model returns the sum of the 25 window words.
// Instance a uses PIM_LAT=1, instance b uses PIM_LAT=3; sel steers the shared stimulus to one of them.
// Expected windows/results are queued at pixel drive time and popped on pim_en / result handshake.
module tb_conv55_6_pim_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       pix_valid;
  logic [5:0] pix_data;
  logic       res_ready;

  logic         pv_a, pr_a, pe_a, rv_a, rl_a;
  logic [149:0] wd_a;
  logic [4:0]   pa_a;
  logic [17:0]  pres_a, rd_a;

  logic         pv_b, pr_b, pe_b, rv_b, rl_b;
  logic [149:0] wd_b;
  logic [4:0]   pa_b;
  logic [17:0]  pres_b, rd_b;

  assign pv_a = pix_valid & ~sel;
  assign pv_b = pix_valid &  sel;

  conv55_6_pim_feeder #(.IMG_W(6), .IMG_H(6), .PIM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv_a), .pix_ready(pr_a), .pix_data(pix_data),
    .win_data(wd_a), .pim_addr(pa_a), .pim_en(pe_a), .pim_result(pres_a),
    .res_valid(rv_a), .res_ready(res_ready), .res_data(rd_a), .res_last(rl_a));

  conv55_6_pim_feeder #(.IMG_W(6), .IMG_H(6), .PIM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv_b), .pix_ready(pr_b), .pix_data(pix_data),
    .win_data(wd_b), .pim_addr(pa_b), .pim_en(pe_b), .pim_result(pres_b),
    .res_valid(rv_b), .res_ready(res_ready), .res_data(rd_b), .res_last(rl_b));

  logic         pr_m, pe_m, rv_m, rl_m;
  logic [149:0] wd_m;
  logic [17:0]  rd_m;
  assign pr_m = sel ? pr_b : pr_a;
  assign pe_m = sel ? pe_b : pe_a;
  assign rv_m = sel ? rv_b : rv_a;
  assign rl_m = sel ? rl_b : rl_a;
  assign wd_m = sel ? wd_b : wd_a;
  assign rd_m = sel ? rd_b : rd_a;

  function automatic logic [17:0] wsum(input logic [149:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 25; i++) s += int'(w[6*i +: 6]);
    return 18'(s);
  endfunction

  // PIM model, latency 1: garbage except in the cycle after pim_en.
  always @(posedge clk) pres_a <= pe_a ? wsum(wd_a) : 18'($urandom);

  // PIM model, latency 3: result only in the third cycle after pim_en.
  logic [2:0]  pvld_b = 3'b000;
  logic [17:0] pd_b [3];
  logic [17:0] garb_b = 18'h0;
  always @(posedge clk) begin
    garb_b   <= 18'($urandom);
    pvld_b   <= {pvld_b[1:0], pe_b};
    pd_b[0]  <= wsum(wd_b);
    pd_b[1]  <= pd_b[0];
    pd_b[2]  <= pd_b[1];
  end
  assign pres_b = pvld_b[2] ? pd_b[2] : garb_b;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [149:0] obs, input logic [149:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [17:0] sum;
    logic [5:0]  w0;
    logic [5:0]  w24;
    logic        last;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  logic [5:0] img [6][6];
  int tr = 0;
  int tc = 0;

  // Drive one pixel (mode 0: ramp 6r+c, mode 1: constant 63) and queue any window it completes.
  task automatic send_px(input int mode);
    logic [5:0] d;
    int n;
    int s;
    exp_t e;
    d = (mode == 0) ? 6'(6*tr + tc) : 6'd63;
    pix_valid = 1'b1;
    pix_data  = d;
    n = 0;
    while (!pr_m && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 500) else begin
      bad++;
      $error("FAIL accept_timeout observed=%0d required_below=500", n);
    end
    img[tr][tc] = d;
    if (tr >= 4 && tc >= 4) begin
      s = 0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          s += int'(img[tr-4+i][tc-4+j]);
      e.sum  = 18'(s);
      e.w0   = img[tr-4][tc-4];
      e.w24  = d;
      e.last = (tr == 5 && tc == 5);
      wq.push_back(e);
      rq.push_back(e);
    end
    tc++;
    if (tc == 6) begin
      tc = 0;
      tr = (tr == 5) ? 0 : tr + 1;
    end
    @(negedge clk);
  endtask

  task automatic send_n(input int cnt, input int mode);
    for (int i = 0; i < cnt; i++) send_px(mode);
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || rv_m) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 3000) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d required_below=3000", n);
    end
  endtask

  // Monitor: window contents at pim_en, result latency, result value/last at handshake.
  int   cyc    = 0;
  int   en_cyc = 0;
  int   npim   = 0;
  int   nres   = 0;
  logic rv_prev = 1'b0;
  logic pe_prev = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      if (pe_m) begin
        npim++;
        chk("pim_en_single_cycle", 150'(pe_prev), 150'(0));
        chk("window_expected", 150'(wq.size() != 0), 150'(1));
        if (wq.size() != 0) begin
          me = wq.pop_front();
          chk("win_word0", 150'(wd_m[5:0]), 150'(me.w0));
          chk("win_word24", 150'(wd_m[149:144]), 150'(me.w24));
        end
        en_cyc = cyc;
      end
      if (rv_m && !rv_prev)
        chk("result_latency", 150'(cyc - en_cyc), 150'(sel ? 4 : 2));
      if (rv_m && res_ready) begin
        nres++;
        chk("result_expected", 150'(rq.size() != 0), 150'(1));
        if (rq.size() != 0) begin
          me = rq.pop_front();
          chk("res_data", 150'(rd_m), 150'(me.sum));
          chk("res_last", 150'(rl_m), 150'(me.last));
        end
      end
      rv_prev = rv_m;
      pe_prev = pe_m;
    end else begin
      rv_prev = 1'b0;
      pe_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $error("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0]  hd;
    logic [149:0] hw;
    int n;

    // Reset values.
    rst_n = 1'b0; sel = 1'b0; pix_valid = 1'b0; pix_data = 6'd0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", 150'(pr_a), 150'(0));
    chk("rst_pim_en", 150'(pe_a), 150'(0));
    chk("rst_res_valid", 150'(rv_a), 150'(0));
    chk("rst_res_last", 150'(rl_a), 150'(0));
    chk("rst_res_data", 150'(rd_a), 150'(0));
    chk("rst_win_data", wd_a, 150'(0));
    chk("pim_addr_a", 150'(pa_a), 150'(0));
    chk("pim_addr_b", 150'(pa_b), 150'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // Ramp frame: 350, 375, 500, 525.
    send_n(36, 0);
    drain();

    // Constant 63 frame: four results of 1575.
    send_n(36, 1);
    drain();

    // Consumer stall on the first result of a ramp frame.
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    fork
      send_n(36, 0);
      begin
        n = 0;
        while (!rv_m && n < 2000) begin
          @(negedge clk);
          n++;
        end
        chk("stall_valid_seen", 150'(rv_m), 150'(1));
        hd = rd_m;
        hw = wd_m;
        repeat (10) begin
          @(negedge clk);
          chk("stall_res_valid", 150'(rv_m), 150'(1));
          chk("stall_res_data", 150'(rd_m), 150'(hd));
          chk("stall_win_data", wd_m, hw);
          chk("stall_pix_ready", 150'(pr_m), 150'(0));
        end
        @(posedge clk); #1 res_ready = 1'b1;
      end
    join
    drain();

    // Reset after 20 pixels, then a fresh ramp frame.
    send_n(20, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_pix_ready", 150'(pr_a), 150'(0));
    chk("midrst_pim_en", 150'(pe_a), 150'(0));
    chk("midrst_res_valid", 150'(rv_a), 150'(0));
    chk("midrst_res_last", 150'(rl_a), 150'(0));
    chk("midrst_res_data", 150'(rd_a), 150'(0));
    chk("midrst_win_data", wd_a, 150'(0));
    tr = 0; tc = 0;
    wq.delete();
    rq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    send_n(36, 0);
    drain();

    // Two back-to-back frames: last only on 4th and 8th results.
    send_n(72, 0);
    drain();

    // PIM_LAT=3 instance.
    sel = 1'b1;
    @(negedge clk);
    send_n(36, 0);
    drain();

    chk("pim_en_per_result", 150'(npim), 150'(nres));
    chk("result_count", 150'(nres), 150'(28));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
